// File: rtl/spike_step_sequencer_if.sv
// Handshake bundle between the step sequencer and the neuron unit, fire FIFO
// and synaptic update processor.
interface spike_step_sequencer_if #(
  parameter int unsigned tagbits = 1
);
  logic               nu_req;
  logic [tagbits-1:0] nu_tag;
  logic               nu_ack;
  logic               nu_fired;

  logic               ff_enq;
  logic               ff_deq;
  logic [tagbits-1:0] ff_in_tag;
  logic [tagbits-1:0] ff_out_tag;
  logic               ff_full;
  logic               ff_empty;

  logic               syn_valid;
  logic [tagbits-1:0] syn_tag;
  logic               syn_ready;

  modport master (
    output nu_req, nu_tag, ff_enq, ff_deq, ff_in_tag, syn_valid, syn_tag,
    input  nu_ack, nu_fired, ff_out_tag, ff_full, ff_empty, syn_ready
  );

  modport slave (
    input  nu_req, nu_tag, ff_enq, ff_deq, ff_in_tag, syn_valid, syn_tag,
    output nu_ack, nu_fired, ff_out_tag, ff_full, ff_empty, syn_ready
  );
endinterface

// File: rtl/spike_step_sequencer.sv
// Sequences one time step: sweep neurons into the fire FIFO, then drain it to the
// synaptic processor. Define FIRE_COUNT_EN to add the fire_count output.
module spike_step_sequencer #(
  parameter int unsigned numneurons = 2,
  parameter int unsigned tagbits    = 1,
  parameter int unsigned stepbits   = 16
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  start,
  spike_step_sequencer_if.master bus,
  output logic                  busy,
  output logic                  step_done,
  output logic [stepbits-1:0]   step_count,
  output logic                  overflow
`ifdef FIRE_COUNT_EN
  ,
  output logic [tagbits:0]      fire_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    NREQ,
    NPOST,
    DSETTLE,
    DISSUE,
    DONE
  } state_t;

  localparam logic [tagbits-1:0] last_idx = tagbits'(numneurons - 1);

  state_t             state_q, state_d;
  logic [tagbits-1:0] idx_q, idx_d;
  logic [tagbits-1:0] tag_q, tag_d;
  logic               fired_q, fired_d;

  logic               nu_req_c;
  logic [tagbits-1:0] nu_tag_c;
  logic               ff_enq_c;
  logic               ff_deq_c;
  logic [tagbits-1:0] ff_in_tag_c;
  logic               syn_valid_c;
  logic [tagbits-1:0] syn_tag_c;
  logic               drop_c;
  logic               step_begin_c;
  logic               step_end_c;

  // State and step bookkeeping registers
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tag_q      <= '0;
      fired_q    <= 1'b0;
      step_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      fired_q <= fired_d;
      if (step_end_c) step_count <= step_count + stepbits'(1);
      if (drop_c)     overflow   <= 1'b1;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    fired_d      = fired_q;
    nu_req_c     = 1'b0;
    nu_tag_c     = '0;
    ff_enq_c     = 1'b0;
    ff_deq_c     = 1'b0;
    ff_in_tag_c  = '0;
    syn_valid_c  = 1'b0;
    syn_tag_c    = '0;
    drop_c       = 1'b0;
    step_begin_c = 1'b0;
    step_end_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = NREQ;
          idx_d        = '0;
          step_begin_c = 1'b1;
        end
      end
      NREQ: begin
        nu_req_c = 1'b1;
        nu_tag_c = idx_q;
        if (bus.nu_ack) begin
          fired_d = bus.nu_fired;
          tag_d   = idx_q;
          state_d = NPOST;
        end
      end
      NPOST: begin
        // A fired tag that finds the FIFO full is lost and flagged sticky
        if (fired_q) begin
          if (bus.ff_full) begin
            drop_c = 1'b1;
          end else begin
            ff_enq_c    = 1'b1;
            ff_in_tag_c = tag_q;
          end
        end
        if (idx_q == last_idx) begin
          state_d = DSETTLE;
        end else begin
          idx_d   = idx_q + tagbits'(1);
          state_d = NREQ;
        end
      end
      DSETTLE: begin
        state_d = DISSUE;
      end
      DISSUE: begin
        if (bus.ff_empty) begin
          state_d = DONE;
        end else begin
          syn_valid_c = 1'b1;
          syn_tag_c   = bus.ff_out_tag;
          if (bus.syn_ready) begin
            ff_deq_c = 1'b1;
            state_d  = DSETTLE;
          end
        end
      end
      DONE: begin
        step_end_c = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.nu_req    = nu_req_c;
  assign bus.nu_tag    = nu_tag_c;
  assign bus.ff_enq    = ff_enq_c;
  assign bus.ff_deq    = ff_deq_c;
  assign bus.ff_in_tag = ff_in_tag_c;
  assign bus.syn_valid = syn_valid_c;
  assign bus.syn_tag   = syn_tag_c;
  assign busy          = (state_q != IDLE);
  assign step_done     = step_end_c;

`ifdef FIRE_COUNT_EN
  // Fires enqueued during the current (or most recent) step
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      fire_count <= '0;
    end else if (step_begin_c) begin
      fire_count <= '0;
    end else if (ff_enq_c) begin
      fire_count <= fire_count + (tagbits + 1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_spike_step_sequencer.sv
// Randomized and directed bench for spike_step_sequencer with a behavioural
// neuron unit, fire FIFO and synaptic processor around it.
module tb_spike_step_sequencer;

  localparam int unsigned N  = 2;
  localparam int unsigned TB = 1;
  localparam int unsigned SB = 16;

  logic          clk = 1'b0;
  logic          asyn_reset;
  logic          start;
  logic          busy;
  logic          step_done;
  logic [SB-1:0] step_count;
  logic          overflow;
`ifdef FIRE_COUNT_EN
  logic [TB:0]   fire_count;
`endif

  spike_step_sequencer_if #(.tagbits(TB)) bus ();

  spike_step_sequencer #(
    .numneurons(N),
    .tagbits   (TB),
    .stepbits  (SB)
  ) dut (
    .clk       (clk),
    .asyn_reset(asyn_reset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .step_done (step_done),
    .step_count(step_count),
    .overflow  (overflow)
`ifdef FIRE_COUNT_EN
    ,
    .fire_count(fire_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Environment configuration for the current step
  logic [N-1:0] fire_vec  = '0;
  logic [N-1:0] full_mask = '0;
  logic         full_force = 1'b0;
  int           ack_dly   = 0;
  int           ready_dly = 0;
  bit           ack_always   = 1'b0;
  bit           ready_always = 1'b0;

  // Reference expectations accumulated across steps
  int   exp_steps = 0;
  logic exp_ovf   = 1'b0;

  // Observation logs filled by the monitor
  int enq_log[$];
  int syn_log[$];
  int tag_log[$];
  int deq_n  = 0;
  int done_n = 0;

  // Fire FIFO: strobes captured mid-cycle, applied on the clock edge
  logic          fifo_empty_r = 1'b1;
  logic          fifo_full_r  = 1'b0;
  logic [TB-1:0] fifo_head_r  = '0;
  logic [TB-1:0] fq[$];
  assign bus.ff_empty   = fifo_empty_r;
  assign bus.ff_full    = fifo_full_r | full_force;
  assign bus.ff_out_tag = fifo_head_r;

  initial begin
    logic          pe, pd;
    logic [TB-1:0] pt;
    forever begin
      @(negedge clk);
      pe = bus.ff_enq & ~asyn_reset;
      pd = bus.ff_deq & ~asyn_reset;
      pt = bus.ff_in_tag;
      @(posedge clk or posedge asyn_reset);
      if (asyn_reset) begin
        fq.delete();
      end else begin
        if (pe && fq.size() < int'(N)) fq.push_back(pt);
        if (pd && fq.size() > 0) void'(fq.pop_front());
      end
      fifo_empty_r <= (fq.size() == 0);
      fifo_full_r  <= (fq.size() >= int'(N));
      fifo_head_r  <= (fq.size() > 0) ? fq[0] : '0;
    end
  end

  // Neuron update unit: acks after ack_dly wait cycles, or always when tied
  initial begin
    int nw;
    nw = 0;
    bus.nu_ack   = 1'b0;
    bus.nu_fired = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (asyn_reset || !bus.nu_req) begin
        bus.nu_ack   = ack_always;
        bus.nu_fired = 1'b0;
        nw = 0;
      end else if (ack_always || nw >= ack_dly) begin
        bus.nu_ack   = 1'b1;
        bus.nu_fired = fire_vec[bus.nu_tag];
        full_force   = full_mask[bus.nu_tag];
        nw = 0;
      end else begin
        bus.nu_ack   = 1'b0;
        bus.nu_fired = 1'b0;
        nw++;
      end
    end
  end

  // Synaptic processor: ready after ready_dly wait cycles, or always when tied
  initial begin
    int sw;
    sw = 0;
    bus.syn_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (asyn_reset) begin
        bus.syn_ready = 1'b0;
        sw = 0;
      end else if (ready_always) begin
        bus.syn_ready = 1'b1;
      end else if (!bus.syn_valid) begin
        bus.syn_ready = 1'b0;
        sw = 0;
      end else if (sw >= ready_dly) begin
        bus.syn_ready = 1'b1;
        sw = 0;
      end else begin
        bus.syn_ready = 1'b0;
        sw++;
      end
    end
  end

  // Protocol monitor and event logging
  initial begin
    logic p_enq, p_deq, p_sv, p_sr, p_nr, p_na, p_done;
    logic [TB-1:0] p_st, p_nt;
    p_enq = 0; p_deq = 0; p_sv = 0; p_sr = 0; p_nr = 0; p_na = 0; p_done = 0;
    p_st = '0; p_nt = '0;
    forever begin
      @(negedge clk);
      if (asyn_reset) begin
        p_enq = 0; p_deq = 0; p_sv = 0; p_sr = 0; p_nr = 0; p_na = 0; p_done = 0;
      end else begin
        if (bus.ff_enq) begin
          enq_log.push_back(int'(bus.ff_in_tag));
          check("enq_spacing", 32'(p_enq), 32'd0);
        end
        if (bus.ff_deq) begin
          deq_n++;
          check("deq_spacing", 32'(p_deq), 32'd0);
        end
        if (bus.ff_enq || bus.ff_deq)
          check("enq_deq_exclusive", 32'(bus.ff_enq & bus.ff_deq), 32'd0);
        if (bus.syn_valid && bus.syn_ready) begin
          syn_log.push_back(int'(bus.syn_tag));
          check("deq_on_accept", 32'(bus.ff_deq), 32'd1);
        end else if (bus.ff_deq) begin
          check("stray_deq", 32'(bus.ff_deq), 32'd0);
        end
        if (p_sv && !p_sr) begin
          check("syn_valid_hold", 32'(bus.syn_valid), 32'd1);
          check("syn_tag_hold", 32'(bus.syn_tag), 32'(p_st));
        end
        if (p_nr && !p_na) begin
          check("nu_req_hold", 32'(bus.nu_req), 32'd1);
          check("nu_tag_hold", 32'(bus.nu_tag), 32'(p_nt));
        end
        if (bus.nu_req && bus.nu_ack) tag_log.push_back(int'(bus.nu_tag));
        if (step_done) begin
          done_n++;
          check("step_done_pulse", 32'(p_done), 32'd0);
        end
        p_enq = bus.ff_enq;   p_deq = bus.ff_deq;
        p_sv  = bus.syn_valid; p_sr = bus.syn_ready; p_st = bus.syn_tag;
        p_nr  = bus.nu_req;    p_na = bus.nu_ack;    p_nt = bus.nu_tag;
        p_done = step_done;
      end
    end
  end

  // One complete step against the reference expectations
  task automatic run_step(input logic [N-1:0] fv, input logic [N-1:0] fm,
                          input int ad, input int rd, input int restart_at);
    int exp_enq[$];
    int exp_lat, cyc, done0, deq0, d_eff, r_eff;
    fire_vec = fv; full_mask = fm; ack_dly = ad; ready_dly = rd; full_force = 1'b0;
    enq_log.delete(); syn_log.delete(); tag_log.delete();
    done0 = done_n; deq0 = deq_n;
    d_eff = ack_always ? 0 : ad;
    r_eff = ready_always ? 0 : rd;
    for (int i = 0; i < int'(N); i++) begin
      if (fv[i] && !fm[i]) exp_enq.push_back(i);
      if (fv[i] && fm[i])  exp_ovf = 1'b1;
    end
    exp_lat = int'(N) * (d_eff + 2) + 3 + exp_enq.size() * (r_eff + 2);

    @(posedge clk); #1;
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == restart_at);
      @(negedge clk);
    end while (!step_done && cyc < 400);
    start = 1'b0;
    check("latency", 32'(cyc), 32'(exp_lat));

    exp_steps++;
    repeat (4) @(negedge clk);
    check("done_pulses", 32'(done_n - done0), 32'd1);
    check("step_count", 32'(step_count), 32'(exp_steps % 65536));
    check("busy_after_done", 32'(busy), 32'd0);
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("nu_tag_count", 32'(tag_log.size()), 32'(N));
    for (int i = 0; i < int'(N); i++)
      if (i < tag_log.size()) check("nu_tag_order", 32'(tag_log[i]), 32'(i));
    check("enq_count", 32'(enq_log.size()), 32'(exp_enq.size()));
    check("syn_count", 32'(syn_log.size()), 32'(exp_enq.size()));
    check("deq_count", 32'(deq_n - deq0), 32'(exp_enq.size()));
    for (int i = 0; i < exp_enq.size(); i++) begin
      if (i < enq_log.size()) check("enq_tag", 32'(enq_log[i]), 32'(exp_enq[i]));
      if (i < syn_log.size()) check("syn_tag", 32'(syn_log[i]), 32'(exp_enq[i]));
    end
`ifdef FIRE_COUNT_EN
    check("fire_count", 32'(fire_count), 32'(exp_enq.size()));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] fv, fm;
    int wcyc;
    asyn_reset = 1'b1;
    start      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_nu_req", 32'(bus.nu_req), 32'd0);
    check("reset_syn_valid", 32'(bus.syn_valid), 32'd0);
    check("reset_ff_enq", 32'(bus.ff_enq), 32'd0);
    check("reset_step_done", 32'(step_done), 32'd0);
    check("reset_step_count", 32'(step_count), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    asyn_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Tied ack, no fires: 2N+3 cycles, nothing enqueued
    ack_always = 1'b1;
    run_step(2'b00, 2'b00, 0, 0, 0);
    // Both neurons fire, ready tied high
    ready_always = 1'b1;
    run_step(2'b11, 2'b00, 0, 0, 0);
    ack_always   = 1'b0;
    ready_always = 1'b0;
    // Synaptic back-pressure for 5 cycles
    run_step(2'b01, 2'b00, 0, 5, 0);
    // FIFO forced full while neuron 1 fires, then overflow stays sticky
    run_step(2'b11, 2'b10, 0, 0, 0);
    run_step(2'b00, 2'b00, 0, 0, 0);
    // Start while busy with a slow neuron unit
    run_step(2'b10, 2'b00, 3, 0, 2);

    for (int s = 0; s < 24; s++) begin
      fv = N'($urandom);
      fm = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      run_step(fv, fm, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0);
    end

    // Reset while offering a tag to the synaptic processor
    fire_vec = '1; full_mask = '0; ack_dly = 0; ready_dly = 50; full_force = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wcyc = 0;
    while (!bus.syn_valid && wcyc < 100) begin
      @(posedge clk); #1;
      wcyc++;
    end
    check("reach_dissue", 32'(bus.syn_valid), 32'd1);
    #2 asyn_reset = 1'b1;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_syn_valid", 32'(bus.syn_valid), 32'd0);
    check("midreset_ff_deq", 32'(bus.ff_deq), 32'd0);
    check("midreset_nu_req", 32'(bus.nu_req), 32'd0);
    check("midreset_step_count", 32'(step_count), 32'd0);
    check("midreset_overflow", 32'(overflow), 32'd0);
    exp_steps = 0;
    exp_ovf   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    asyn_reset = 1'b0;
    ready_dly  = 0;
    run_step(2'b11, 2'b00, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_step_sequencer.md
Name: spike_step_sequencer

Overview:
- Sequences one simulation time step of the neuron/synapse pipeline.
- Neuron phase: sweeps neuron tags 0..numneurons-1 through the neuron update unit with a req/ack handshake, and enqueues the tag of every neuron that fires into the fire FIFO.
- Drain phase: dequeues every stored tag and hands it to the synaptic update processor with a valid/ready handshake, then signals step completion.
- It is the only producer and the only consumer of the fire FIFO, and it never enqueues and dequeues in the same cycle.

Parameters:
- numneurons, 2, number of neurons swept per step; also the fire FIFO depth.
- tagbits, 1, width of a neuron tag; must satisfy 2^tagbits >= numneurons.
- stepbits, 16, width of the time-step counter.

Ports:
- clk  in  1  clock.
- asyn_reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a time step; sampled only in IDLE.
- nu_req  out  1  request to the neuron update unit.
- nu_tag  out  tagbits  neuron being updated.
- nu_ack  in  1  neuron update unit done; nu_fired is valid in the same cycle.
- nu_fired  in  1  updated neuron crossed threshold.
- ff_enq  out  1  fire FIFO enqueue strobe.
- ff_deq  out  1  fire FIFO dequeue strobe.
- ff_in_tag  out  tagbits  tag to enqueue.
- ff_out_tag  in  tagbits  FIFO head tag.
- ff_full  in  1  FIFO full.
- ff_empty  in  1  FIFO empty.
- syn_valid  out  1  tag offered to the synaptic processor.
- syn_tag  out  tagbits  offered tag.
- syn_ready  in  1  synaptic processor accepts.
- busy  out  1  high in any state other than IDLE.
- step_done  out  1  one-cycle pulse when a step completes.
- step_count  out  stepbits  number of completed steps.
- overflow  out  1  sticky: a fired tag was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0. State IDLE, neuron index 0, step_count 0, overflow 0.
- States:
  - IDLE: start=1 -> NREQ, with index cleared to 0.
  - NREQ: nu_req=1, nu_tag=index. On nu_ack=1 -> NPOST. In that ack cycle, register fired_q=nu_fired and latch the tag.
  - NPOST (exactly 1 cycle): nu_req=0. If fired_q and !ff_full, then ff_enq=1 with ff_in_tag=latched tag. If fired_q and ff_full, the tag is dropped and overflow is set to 1. If index==numneurons-1 -> DSETTLE; else index+1 and -> NREQ.
  - DSETTLE (1 cycle): no strobes; lets FIFO flags update after the last enq/deq.
  - DISSUE: if ff_empty -> DONE. Else syn_valid=1 and syn_tag=ff_out_tag. On syn_ready=1: ff_deq=1 in the same cycle, then -> DSETTLE.
  - DONE (1 cycle): step_done=1, step_count+1 (wraps at 2^stepbits), -> IDLE.
- Flag spacing: ff_enq and ff_deq are each 1-cycle pulses separated by at least 1 idle cycle. ff_enq and ff_deq are never high together.
- syn_valid, once raised, stays high with a stable syn_tag until syn_ready.
- nu_req stays high with a stable nu_tag until nu_ack.
- start while busy is ignored.
- nu_ack outside NREQ and syn_ready outside DISSUE are ignored.
- overflow clears only on reset.
- Latency:
  - A step with 0 fires and a zero-wait neuron unit takes 2*numneurons + 3 cycles from the start cycle to step_done.
  - Each drained tag adds 2 cycles when syn_ready is tied high.
- Reset mid-step: returns to IDLE immediately with all outputs 0. The FIFO shares the reset, so no stale tags remain.

Optional Feature:
- Macro: FIRE_COUNT_EN.
- Defined: adds output fire_count [tagbits:0].
  - Cleared on the start that enters NREQ.
  - Increments on every ff_enq.
  - Holds its value after DONE until the next start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- numneurons=2, nu_ack tied 1, nu_fired=0, start -> nu_tag 0 then 1, no ff_enq, no syn_valid, step_done at cycle 7, step_count=1.
- numneurons=2, both neurons fire, syn_ready=1 -> ff_enq with tag 0 then tag 1; syn_valid with syn_tag 0 then 1; ff_deq twice; step_done; fire_count=2 when enabled.
- Fire with syn_ready held 0 for 5 cycles -> syn_valid and syn_tag held stable, no ff_deq, until syn_ready=1.
- Force ff_full=1 while neuron 1 fires -> no ff_enq, overflow=1, and overflow still 1 after the following step.
- start pulsed while busy, plus nu_ack delayed 3 cycles -> no restart, nu_req held high, single step_done.
- asyn_reset asserted during DISSUE -> busy=0, syn_valid=0, step_count=0 immediately; a new start runs a clean step.
